crossbar_out_arbiter: RTL and testbench
=======================================

Name: crossbar_out_arbiter

Overview:
Output-side stage of the crossbar. It collects the transmit requests of the P_PORTS per-destination crossbar points that target one egress port and grants them round-robin, one packet at a time. While a packet is in flight it muxes the granted point's AXI-Stream output onto the single egress AXI-Stream. It returns the egress tready only to the granted point.

Parameters:
P_PORTS, 4, number of crossbar points (requesters) feeding this egress; 2..8
P_SEL_W, 2, width of the select index; must equal clog2(P_PORTS)
P_TIMEOUT, 16'd1024, cycles without a granted-port beat before forced release (used only with the optional feature)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  asynchronous active-high reset
i_trans_req  in  P_PORTS  per-point request, level, held until granted
o_trans_grant  out  P_PORTS  one-hot grant, single-cycle pulse
s_axis_rx_tvalid  in  P_PORTS  per-point tvalid
s_axis_rx_tdata  in  64*P_PORTS  per-point tdata; port i at [64*i+63:64*i]
s_axis_rx_tlast  in  P_PORTS  per-point tlast
s_axis_rx_tkeep  in  8*P_PORTS  per-point tkeep; port i at [8*i+7:8*i]
s_axis_rx_tready  out  P_PORTS  per-point tready
m_axis_tx_tvalid  out  1  egress tvalid
m_axis_tx_tdata  out  64  egress tdata
m_axis_tx_tlast  out  1  egress tlast
m_axis_tx_tkeep  out  8  egress tkeep
m_axis_tx_tuser  out  1  egress tuser; tied 0
m_axis_tx_tready  in  1  egress tready
o_busy  out  1  high from the grant cycle through the tlast handshake
o_sel  out  P_SEL_W  index of the current or last granted port

Behaviour:
- Reset values:
  - state IDLE.
  - o_trans_grant=0, o_busy=0, o_sel=0.
  - rr pointer = P_PORTS-1, so port 0 has first priority.
  - All s_axis_rx_tready=0, m_axis_tx_tvalid=0, m_axis_tx_tlast=0, m_axis_tx_tkeep=0, m_axis_tx_tdata=0.
- States are IDLE, GRANT and XFER.
- IDLE:
  - If any i_trans_req bit is set, select the first set bit searching from (rr+1) mod P_PORTS upward with wrap.
  - Register the winner into o_sel and go to GRANT.
  - Requests that are all zero keep the block in IDLE.
- GRANT: a single cycle.
  - o_trans_grant[o_sel]=1 for exactly this cycle.
  - rr<=o_sel. Go to XFER.
- XFER:
  - The mux is driven from the registered o_sel.
  - m_axis_tx_tvalid/tdata/tlast/tkeep = s_axis_rx_* of port o_sel.
  - s_axis_rx_tready[o_sel]=m_axis_tx_tready; all other tready bits are 0.
  - A beat is accepted when m_axis_tx_tvalid && m_axis_tx_tready.
  - An accepted beat with tlast returns the block to IDLE on the next edge.
  - The granted point's first beat may arrive any number of cycles after the grant; the block waits in XFER.
- Outside XFER:
  - All egress outputs are 0, including tvalid.
  - All tready bits are 0.
  - tvalid from ungranted ports is ignored.
- Requests are sampled only in IDLE. A port requesting during GRANT or XFER is considered on the next IDLE.
- Throughput and latency:
  - Request-to-grant latency is 2 cycles (IDLE sample, then GRANT pulse).
  - Turnaround after a tlast handshake is 2 cycles minimum before the next grant.
  - Data path is combinational; no added beat latency.
- Fairness: a port that has just been served gets lowest priority in the next arbitration. With all ports requesting, grants rotate 0,1,2,3,0,...
- A request that drops in IDLE before being sampled is not granted.
- Mid-operation reset:
  - Asynchronous return to IDLE with all outputs at reset values.
  - A partial packet on the egress is truncated.
  - The downstream stage is also reset, so no recovery is required.
- A single-beat packet (tvalid and tlast on the first beat) completes XFER in one handshake.

Optional Feature:
Macro CROSSBAR_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on GRANT and on every accepted beat, and increments each XFER cycle otherwise.
  - On reaching P_TIMEOUT the block returns to IDLE and pulses o_timeout (extra 1-bit output port, reset 0) for one cycle. rr still advances past the stalled port.
- When not defined: no counter, no o_timeout port, and XFER waits indefinitely.

Test Plan:
- Reset with i_trans_req=4'b0000 -> grant 0, tvalid 0, all tready 0, o_busy 0.
- Single requester: i_trans_req=4'b0100, 3-beat packet, tkeep 8'h0F on last, tready=1 -> o_trans_grant=4'b0100 two cycles after req. Egress shows 3 beats of port 2 data, tlast on beat 3, tkeep 8'h0F. Then IDLE.
- All four requesting continuously, 2-beat packets -> grant order 0,1,2,3,0. No tready to ungranted ports.
- Backpressure: m_axis_tx_tready toggling 1,0,1,0 during a 4-beat packet from port 1 -> s_axis_rx_tready[1] tracks it exactly. Data is held, 4 beats are accepted, and no state change until the tlast handshake.
- Port 3 tvalid=1 while port 0 is granted -> port 3 data never appears on egress and s_axis_rx_tready[3]=0.
- With CROSSBAR_ARB_TIMEOUT_EN and P_TIMEOUT=16: grant port 1 with no tvalid -> o_timeout pulses at XFER cycle 16. Block returns to IDLE, and the next grant goes to port 2 when ports 1 and 2 both request.

Source files
------------

// File: rtl/crossbar_out_arbiter.sv
// crossbar_out_arbiter
//   Egress-side arbiter of the crossbar. It grants one of P_PORTS crossbar points
//   round-robin, one packet at a time, and muxes the granted point's AXI-Stream
//   onto the single egress stream until the tlast handshake.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_trans_req          per-point level request, held until granted
//   o_trans_grant        one-hot single-cycle grant pulse
//   s_axis_rx_*          per-point AXI-Stream inputs (tdata/tkeep packed per port)
//   m_axis_tx_*          egress AXI-Stream (tuser tied 0)
//   o_busy               high from the grant cycle through the tlast handshake
//   o_sel                index of the current or last granted point
//   o_timeout            (CROSSBAR_ARB_TIMEOUT_EN only) single-cycle stall-release pulse
//
// Build option
//   CROSSBAR_ARB_TIMEOUT_EN: release a granted point that has not moved a beat for
//   P_TIMEOUT cycles. Without it the transfer state waits indefinitely.
module crossbar_out_arbiter #(
  parameter int unsigned  P_PORTS   = 4,
  parameter int unsigned  P_SEL_W   = 2,
  parameter logic [15:0]  P_TIMEOUT = 16'd1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_PORTS-1:0]     i_trans_req,
  output logic [P_PORTS-1:0]     o_trans_grant,
  input  logic [P_PORTS-1:0]     s_axis_rx_tvalid,
  input  logic [64*P_PORTS-1:0]  s_axis_rx_tdata,
  input  logic [P_PORTS-1:0]     s_axis_rx_tlast,
  input  logic [8*P_PORTS-1:0]   s_axis_rx_tkeep,
  output logic [P_PORTS-1:0]     s_axis_rx_tready,
  output logic                   m_axis_tx_tvalid,
  output logic [63:0]            m_axis_tx_tdata,
  output logic                   m_axis_tx_tlast,
  output logic [7:0]             m_axis_tx_tkeep,
  output logic                   m_axis_tx_tuser,
  input  logic                   m_axis_tx_tready,
  output logic                   o_busy,
  output logic [P_SEL_W-1:0]     o_sel
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  ,
  output logic                   o_timeout
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StXfer  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [P_SEL_W-1:0] sel_q, sel_d;
  logic [P_SEL_W-1:0] rr_q, rr_d;
  logic [P_SEL_W-1:0] winner;
  logic               found;
  logic               xfer;
  logic               beat;

  // First requester strictly after the last served point, wrapping around.
  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    for (int unsigned i = 1; i <= P_PORTS; i++) begin
      int unsigned idx;
      idx = (32'(rr_q) + i) % P_PORTS;
      if (!found && i_trans_req[idx]) begin
        found  = 1'b1;
        winner = P_SEL_W'(idx);
      end
    end
  end

  // Egress mux and tready steering; everything is quiet outside XFER.
  always_comb begin
    xfer             = (state_q == StXfer);
    m_axis_tx_tvalid = 1'b0;
    m_axis_tx_tdata  = '0;
    m_axis_tx_tlast  = 1'b0;
    m_axis_tx_tkeep  = '0;
    m_axis_tx_tuser  = 1'b0;
    s_axis_rx_tready = '0;
    o_trans_grant    = '0;
    if (xfer) begin
      m_axis_tx_tvalid        = s_axis_rx_tvalid[sel_q];
      m_axis_tx_tdata         = s_axis_rx_tdata[64*sel_q +: 64];
      m_axis_tx_tlast         = s_axis_rx_tlast[sel_q];
      m_axis_tx_tkeep         = s_axis_rx_tkeep[8*sel_q +: 8];
      s_axis_rx_tready[sel_q] = m_axis_tx_tready;
    end
    if (state_q == StGrant) begin
      o_trans_grant[sel_q] = 1'b1;
    end
    beat   = m_axis_tx_tvalid && m_axis_tx_tready;
    o_busy = (state_q != StIdle);
    o_sel  = sel_q;
  end

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        stall_expired;

  // Expires during the P_TIMEOUT-th consecutive XFER cycle without a beat.
  always_comb begin
    cnt_d         = cnt_q;
    stall_expired = 1'b0;
    if (state_q == StGrant) begin
      cnt_d = '0;
    end else if (xfer) begin
      if (beat) begin
        cnt_d = '0;
      end else begin
        cnt_d         = cnt_q + 16'd1;
        stall_expired = (cnt_d == P_TIMEOUT);
      end
    end
    o_timeout = stall_expired;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic stall_expired;
  logic unused_timeout;
  assign stall_expired  = 1'b0;
  assign unused_timeout = ^P_TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          sel_d   = winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        rr_d    = sel_q;
        state_d = StXfer;
      end
      StXfer: begin
        if ((beat && m_axis_tx_tlast) || stall_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      rr_q    <= P_SEL_W'(P_PORTS - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_crossbar_out_arbiter.sv
// Bench for crossbar_out_arbiter (default build, 4 ports).
module tb_crossbar_out_arbiter;
  localparam int P = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [P-1:0]  i_trans_req;
  logic [P-1:0]  o_trans_grant;
  logic [P-1:0]  s_axis_rx_tvalid;
  logic [64*P-1:0] s_axis_rx_tdata;
  logic [P-1:0]  s_axis_rx_tlast;
  logic [8*P-1:0] s_axis_rx_tkeep;
  logic [P-1:0]  s_axis_rx_tready;
  logic          m_axis_tx_tvalid;
  logic [63:0]   m_axis_tx_tdata;
  logic          m_axis_tx_tlast;
  logic [7:0]    m_axis_tx_tkeep;
  logic          m_axis_tx_tuser;
  logic          m_axis_tx_tready;
  logic          o_busy;
  logic [1:0]    o_sel;

  crossbar_out_arbiter #(.P_PORTS(4), .P_SEL_W(2), .P_TIMEOUT(16'd1024)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_trans_req      (i_trans_req),
    .o_trans_grant    (o_trans_grant),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tkeep  (s_axis_rx_tkeep),
    .s_axis_rx_tready (s_axis_rx_tready),
    .m_axis_tx_tvalid (m_axis_tx_tvalid),
    .m_axis_tx_tdata  (m_axis_tx_tdata),
    .m_axis_tx_tlast  (m_axis_tx_tlast),
    .m_axis_tx_tkeep  (m_axis_tx_tkeep),
    .m_axis_tx_tuser  (m_axis_tx_tuser),
    .m_axis_tx_tready (m_axis_tx_tready),
    .o_busy           (o_busy),
    .o_sel            (o_sel)
  );

  always #5 i_clk = ~i_clk;

  int           n_vec = 0;
  int           n_err = 0;
  int           last_srv = P - 1;  // model: most recently served port
  logic [P-1:0] pend = '0;         // model: requests still waiting for a grant

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Winner = requester at the smallest positive rotational distance from last_srv.
  function automatic int pick(input logic [P-1:0] r, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = P + 1;
    for (int p = 0; p < P; p++) begin
      d = (p - last - 1 + 2 * P) % P;
      if (r[p] && d < bestd) begin
        bestd = d;
        best  = p;
      end
    end
    return best;
  endfunction

  // Random traffic on every port except 'w' (force_valid: all of them assert tvalid).
  task automatic noise(input int w, input bit force_valid);
    for (int p = 0; p < P; p++) begin
      if (p != w) begin
        s_axis_rx_tvalid[p]         = force_valid ? 1'b1 : 1'($urandom);
        s_axis_rx_tdata[64*p +: 64] = {$urandom, $urandom};
        s_axis_rx_tlast[p]          = 1'($urandom);
        s_axis_rx_tkeep[8*p +: 8]   = 8'($urandom);
      end
    end
  endtask

  task automatic apply_reset();
    i_rst            = 1'b1;
    i_trans_req      = '0;
    s_axis_rx_tvalid = '0;
    s_axis_rx_tdata  = '0;
    s_axis_rx_tlast  = '0;
    s_axis_rx_tkeep  = '0;
    m_axis_tx_tready = 1'b0;
    pend             = '0;
    last_srv         = P - 1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  // One arbitration + packet. Starts and ends in an IDLE cycle.
  // mode 0: tready=1, 1: random tvalid/tready, 2: tready 1,0,1,0..., 3: others tvalid=1
  task automatic do_packet(input logic [P-1:0] newreq, input int len, input int mode,
                           input logic [7:0] last_keep, input string tag);
    int w, b, gap;
    logic [63:0] d;
    logic [7:0]  k;
    logic        v, rdy, lst;
    bit          done;
    pend        = pend | newreq;
    i_trans_req = pend;
    w = pick(pend, last_srv);
    noise(-1, 1'b0);
    tick();
    noise(w, mode == 3);
    #1;
    n_vec++;
    if (o_trans_grant !== P'(1 << w) || o_sel !== 2'(w) || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s grant: grant=%b sel=%0d busy=%b, need grant=%b sel=%0d busy=1",
               tag, o_trans_grant, o_sel, o_busy, P'(1 << w), w);
    end
    n_vec++;
    if (m_axis_tx_tvalid !== 1'b0 || s_axis_rx_tready !== '0) begin
      n_err++;
      $display("FAIL %s grant_quiet: tvalid=%b tready=%b, need 0/0000", tag,
               m_axis_tx_tvalid, s_axis_rx_tready);
    end
    pend[w]     = 1'b0;
    i_trans_req = pend;
    gap = (mode == 2) ? 0 : int'($urandom_range(0, 2));
    tick();
    b    = 0;
    d    = {$urandom, $urandom};
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      noise(w, mode == 3);
      if (gap > 0) begin
        v = 1'b0;
        gap--;
      end else begin
        v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      case (mode)
        1:       rdy = 1'($urandom);
        2:       rdy = (cyc % 2 == 0);
        default: rdy = 1'b1;
      endcase
      lst = (b == len - 1);
      k   = lst ? last_keep : 8'hFF;
      s_axis_rx_tvalid[w]         = v;
      s_axis_rx_tdata[64*w +: 64] = d;
      s_axis_rx_tlast[w]          = lst;
      s_axis_rx_tkeep[8*w +: 8]   = k;
      m_axis_tx_tready            = rdy;
      #1;
      n_vec++;
      if (m_axis_tx_tvalid !== v || (v && (m_axis_tx_tdata !== d || m_axis_tx_tlast !== lst ||
          m_axis_tx_tkeep !== k))) begin
        n_err++;
        $display("FAIL %s beat%0d: v=%b d=%h l=%b k=%h, need v=%b d=%h l=%b k=%h", tag, b,
                 m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast, m_axis_tx_tkeep,
                 v, d, lst, k);
      end
      n_vec++;
      if (s_axis_rx_tready !== (rdy ? P'(1 << w) : P'(0)) || o_busy !== 1'b1 ||
          o_trans_grant !== '0 || m_axis_tx_tuser !== 1'b0) begin
        n_err++;
        $display("FAIL %s xfer_ctl: tready=%b busy=%b grant=%b tuser=%b, need tready=%b busy=1",
                 tag, s_axis_rx_tready, o_busy, o_trans_grant, m_axis_tx_tuser,
                 rdy ? P'(1 << w) : P'(0));
      end
      if (v && rdy) begin
        if (lst) done = 1'b1;
        else begin
          b++;
          d = {$urandom, $urandom};
        end
      end
      tick();
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s packet_end: packet not completed within bound, need %0d beats", tag, len);
    end
    noise(-1, 1'b0);
    m_axis_tx_tready = 1'($urandom);
    #1;
    n_vec++;
    if (o_busy !== 1'b0 || m_axis_tx_tvalid !== 1'b0 || s_axis_rx_tready !== '0 ||
        o_trans_grant !== '0) begin
      n_err++;
      $display("FAIL %s idle_after: busy=%b tvalid=%b tready=%b grant=%b, need all 0", tag,
               o_busy, m_axis_tx_tvalid, s_axis_rx_tready, o_trans_grant);
    end
    last_srv = w;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_trans_req = '0;
    noise(-1, 1'b1);
    m_axis_tx_tready = 1'b1;
    tick();
    n_vec++;
    if (o_trans_grant !== '0 || m_axis_tx_tvalid !== 1'b0 || s_axis_rx_tready !== '0 ||
        o_busy !== 1'b0 || o_sel !== 2'd0 || m_axis_tx_tdata !== '0 ||
        m_axis_tx_tkeep !== '0 || m_axis_tx_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: grant=%b tvalid=%b tready=%b busy=%b sel=%0d, need all 0",
               o_trans_grant, m_axis_tx_tvalid, s_axis_rx_tready, o_busy, o_sel);
    end
    i_rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if (o_busy !== 1'b0 || o_trans_grant !== '0) begin
      n_err++;
      $display("FAIL reset_noreq_idle: busy=%b grant=%b, need 0/0000", o_busy, o_trans_grant);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    do_packet(4'b0100, 3, 0, 8'h0F, "single");
  endtask

  task automatic test_rotation();
    apply_reset();
    for (int i = 0; i < 5; i++) do_packet(4'b1111, 2, 0, 8'hFF, "rotate");
  endtask

  task automatic test_backpressure();
    apply_reset();
    do_packet(4'b0010, 4, 2, 8'h3F, "backpressure");
  endtask

  task automatic test_isolation();
    apply_reset();
    do_packet(4'b0001, 3, 3, 8'h01, "isolation");
  endtask

  task automatic test_req_drop();
    apply_reset();
    i_trans_req = 4'b1000;
    #2;
    i_trans_req = 4'b0000;
    tick();
    tick();
    n_vec++;
    if (o_trans_grant !== '0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL req_drop: grant=%b busy=%b, need 0000/0", o_trans_grant, o_busy);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    i_trans_req = 4'b0100;
    tick();
    i_trans_req = '0;
    tick();
    s_axis_rx_tvalid = 4'b0100;
    s_axis_rx_tdata[128 +: 64] = 64'hDEAD_BEEF_0123_4567;
    m_axis_tx_tready = 1'b1;
    #3;
    i_rst = 1'b1;
    #1;
    n_vec++;
    if (o_busy !== 1'b0 || m_axis_tx_tvalid !== 1'b0 || s_axis_rx_tready !== '0 ||
        o_sel !== 2'd0 || m_axis_tx_tdata !== '0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b tvalid=%b tready=%b sel=%0d, need all 0",
               o_busy, m_axis_tx_tvalid, s_axis_rx_tready, o_sel);
    end
    apply_reset();
    do_packet(4'b1111, 1, 0, 8'h80, "post_reset");
  endtask

  task automatic test_random();
    logic [P-1:0] r;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      r = P'($urandom_range(0, 15));
      if ((pend | r) == '0) r = P'(1 << $urandom_range(0, P - 1));
      do_packet(r, int'($urandom_range(1, 4)), 1, 8'($urandom_range(1, 255)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_isolation();
    test_req_drop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
